// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and data access (MEM). Data has priority over fetch. Each grant holds a
// registered request on the memory side until mem_ready, then returns a
// one-cycle ack with registered read data.
//
// Optional build macro ARB_FAIR_EN: bounds fetch starvation. After FAIR_LIMIT
// consecutive data grants taken while a fetch was waiting, the next decision
// goes to the fetch. When the macro is undefined, data priority is strict.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; arbitrates when neither ack is high
// GNT_I | fetch access on the memory, waiting for mem_ready
// GNT_D | data access on the memory, waiting for mem_ready
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state;
  logic       ifElig;
  logic       dElig;
  logic       decide;
  logic       fetchTurn;
  logic       pickD;
  logic       pickI;

  assign ifElig = if_req & ~if_ack;
  assign dElig  = d_req & ~d_ack;

  // The ack cycle is a turnaround: no decision is taken while either ack is
  // high, so a requester that keeps its level high after its ack is seen as a
  // fresh request only in the following cycle, and the stale one is never
  // granted twice.
  assign decide = (state == IDLE) & ~if_ack & ~d_ack;

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(FAIR_LIMIT + 2);

  logic [CW-1:0] fairCnt;

  assign fetchTurn = ifElig & (fairCnt == CW'(FAIR_LIMIT));

  // Count data grants taken while a fetch waits; any fetch grant or a
  // decision with no waiting fetch starts the count over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fairCnt <= '0;
    end else if (decide) begin
      if (pickI || !ifElig) begin
        fairCnt <= '0;
      end else if (pickD) begin
        fairCnt <= fairCnt + CW'(1);
      end
    end
  end
`else
  assign fetchTurn = 1'b0;
`endif

  assign pickD = decide & dElig & ~fetchTurn;
  assign pickI = decide & ifElig & ~pickD;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  // Grant FSM: capture the winner on entry, hold mem_* for the whole access,
  // and retire with a single-cycle ack plus registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (pickD) begin
            state     <= GNT_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (pickI) begin
            state     <= GNT_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        GNT_I: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        GNT_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_ack   <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level reference of the arbiter.
module tb_mem_port_arbiter;

  localparam int FAIR_LIMIT = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR_ON = 1'b1;
`else
  localparam bit FAIR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_if;
  logic        stall_mem;

  int vecs = 0;
  int miss = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Reference: one access at most in flight; it finishes on mem_ready and is
  // acknowledged next cycle; a new winner is chosen only when no ack is
  // showing; data beats fetch unless the fairness streak has run out.
  logic        eIfAck, eDAck, eMemReq, eMemWe;
  logic [31:0] eMemAddr, eMemWdata, eIfRdata, eDRdata;
  bit          inFlight, flightIsData, newIfAck, newDAck, fetchTurn;
  int          streak;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {eIfAck, eDAck, eMemReq, eMemWe} = '0;
      {eMemAddr, eMemWdata, eIfRdata, eDRdata} = '0;
      inFlight = 0;
      flightIsData = 0;
      streak = 0;
    end else begin
      newIfAck = 0;
      newDAck = 0;
      if (inFlight) begin
        if (mem_ready) begin
          inFlight = 0;
          eMemReq = 0;
          if (flightIsData) begin
            newDAck = 1;
            if (!eMemWe) eDRdata = mem_rdata;
          end else begin
            newIfAck = 1;
            eIfRdata = mem_rdata;
          end
        end
      end else if (!eIfAck && !eDAck) begin
        fetchTurn = FAIR_ON && if_req && (streak == FAIR_LIMIT);
        if (d_req && !fetchTurn) begin
          inFlight = 1; flightIsData = 1;
          eMemReq = 1; eMemWe = d_we; eMemAddr = d_addr; eMemWdata = d_wdata;
          streak = if_req ? streak + 1 : 0;
        end else if (if_req) begin
          inFlight = 1; flightIsData = 0;
          eMemReq = 1; eMemWe = 0; eMemAddr = if_addr; eMemWdata = 0;
          streak = 0;
        end else begin
          streak = 0;
        end
      end
      eIfAck = newIfAck;
      eDAck = newDAck;
    end
  end

  function automatic logic [133:0] packObs();
    return {if_ack, d_ack, mem_req, mem_we, stall_if, stall_mem,
            mem_addr, mem_wdata, if_rdata, d_rdata};
  endfunction

  function automatic logic [133:0] packExp();
    return {eIfAck, eDAck, eMemReq, eMemWe, if_req & ~eIfAck, d_req & ~eDAck,
            eMemAddr, eMemWdata, eIfRdata, eDRdata};
  endfunction

  task automatic doReset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (packObs() !== 134'd0) begin
      miss++;
      $display("FAIL reset_values: dut=%h want=0", packObs());
    end
    vecs++;
    if (packObs() !== packExp()) begin
      miss++;
      $display("FAIL reset_model: dut=%h ref=%h", packObs(), packExp());
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_only();
    doReset();
    if_req = 1; if_addr = 32'h100;
    #1;
    vecs++;
    if (stall_if !== 1'b1) begin miss++; $display("FAIL fetch_stall_N: dut=%b want=1", stall_if); end
    @(negedge clk);
    vecs++;
    if ({mem_req, mem_we, mem_addr, stall_if} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
      miss++;
      $display("FAIL fetch_grant: req/we/addr/stall=%b/%b/%h/%b want 1/0/00000100/1",
               mem_req, mem_we, mem_addr, stall_if);
    end
    mem_ready = 1; mem_rdata = 32'h8C220004;
    @(negedge clk);
    vecs++;
    if ({if_ack, if_rdata, mem_req, stall_if} !== {1'b1, 32'h8C220004, 1'b0, 1'b0}) begin
      miss++;
      $display("FAIL fetch_ack: ack/rdata/req/stall=%b/%h/%b/%b want 1/8c220004/0/0",
               if_ack, if_rdata, mem_req, stall_if);
    end
    vecs++;
    if (packObs() !== packExp()) begin miss++; $display("FAIL fetch_model: dut=%h ref=%h", packObs(), packExp()); end
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    vecs++;
    if (if_ack !== 1'b0) begin miss++; $display("FAIL fetch_ack_pulse: dut=%b want=0", if_ack); end
  endtask

  task automatic test_priority();
    int dAt, iAt;
    dAt = -1; iAt = -1;
    doReset();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vecs++;
      if (packObs() !== packExp()) begin miss++; $display("FAIL prio_model c%0d: dut=%h ref=%h", c, packObs(), packExp()); end
      if (c == 1) begin
        vecs++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF}) begin
          miss++;
          $display("FAIL prio_first_grant: req/we/addr/wdata=%b/%b/%h/%h want 1/1/00002000/deadbeef",
                   mem_req, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 3) begin
        vecs++;
        if (stall_if !== 1'b1) begin miss++; $display("FAIL prio_stall_if: dut=%b want=1", stall_if); end
      end
      if (d_ack && dAt < 0) begin dAt = c; d_req = 0; end
      if (if_ack && iAt < 0) begin iAt = c; if_req = 0; end
    end
    vecs++;
    if (dAt != 2 || iAt != 5) begin
      miss++;
      $display("FAIL prio_ack_timing: d_ack@%0d if_ack@%0d want 2 and 5", dAt, iAt);
    end
  endtask

  task automatic test_wait_state();
    logic [31:0] rd;
    rd = 32'hC0FFEE01;
    doReset();
    d_req = 1; d_we = 0; d_addr = 32'h2004; d_wdata = 32'h5555AAAA;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vecs++;
      if ({mem_req, mem_addr, d_rdata, stall_mem, d_ack} !== {1'b1, 32'h2004, 32'h0, 1'b1, 1'b0}) begin
        miss++;
        $display("FAIL wait_hold c%0d: req/addr/rdata/stall/ack=%b/%h/%h/%b/%b want 1/00002004/0/1/0",
                 c, mem_req, mem_addr, d_rdata, stall_mem, d_ack);
      end
      vecs++;
      if (packObs() !== packExp()) begin miss++; $display("FAIL wait_model c%0d: dut=%h ref=%h", c, packObs(), packExp()); end
      d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
    end
    mem_ready = 1; mem_rdata = rd;
    @(negedge clk);
    vecs++;
    if ({d_ack, d_rdata, stall_mem} !== {1'b1, rd, 1'b0}) begin
      miss++;
      $display("FAIL wait_ack: ack/rdata/stall=%b/%h/%b want 1/%h/0", d_ack, d_rdata, stall_mem, rd);
    end
    d_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset_mid_grant();
    int dAt, iAt;
    dAt = -1; iAt = -1;
    doReset();
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    if_req = 1; if_addr = 32'h200;
    repeat (2) @(negedge clk);
    vecs++;
    if (mem_req !== 1'b1) begin miss++; $display("FAIL rst_pre_grant: mem_req=%b want 1", mem_req); end
    reset = 1'b1;
    #1;
    vecs++;
    if ({mem_req, d_ack, if_ack} !== 3'b000) begin
      miss++;
      $display("FAIL rst_async: req/d_ack/if_ack=%b/%b/%b want 0/0/0", mem_req, d_ack, if_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1; mem_rdata = 32'h77778888;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vecs++;
      if (packObs() !== packExp()) begin miss++; $display("FAIL rst_model c%0d: dut=%h ref=%h", c, packObs(), packExp()); end
      if (c == 1) begin
        vecs++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h3000}) begin
          miss++;
          $display("FAIL rst_regrant: req/we/addr=%b/%b/%h want 1/0/00003000", mem_req, mem_we, mem_addr);
        end
      end
      if (d_ack && dAt < 0) begin dAt = c; d_req = 0; end
      if (if_ack && iAt < 0) begin iAt = c; if_req = 0; end
    end
    vecs++;
    if (dAt != 2 || iAt != 5) begin
      miss++;
      $display("FAIL rst_rearb: d_ack@%0d if_ack@%0d want 2 and 5", dAt, iAt);
    end
    mem_ready = 0;
  endtask

  task automatic test_fairness();
    int dSince, dTotal, iTotal, wantI, wantD;
    dSince = 0; dTotal = 0; iTotal = 0;
    doReset();
    d_req = 1; d_we = 0; d_addr = $urandom;
    if_req = 1; if_addr = $urandom;
    mem_ready = 1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      vecs++;
      if (packObs() !== packExp()) begin miss++; $display("FAIL fair_model c%0d: dut=%h ref=%h", c, packObs(), packExp()); end
      mem_rdata = $urandom;
      if (d_ack) begin dSince++; dTotal++; d_addr = $urandom; d_we = 1'($urandom); end
      if (if_ack) begin
        iTotal++;
        vecs++;
        if (dSince != FAIR_LIMIT) begin
          miss++;
          $display("FAIL fair_streak: %0d data grants before fetch, want %0d", dSince, FAIR_LIMIT);
        end
        dSince = 0;
        if_addr = $urandom;
      end
    end
    wantI = FAIR_ON ? 4 : 0;
    wantD = FAIR_ON ? 16 : 20;
    vecs++;
    if (iTotal != wantI || dTotal != wantD) begin
      miss++;
      $display("FAIL fair_totals: fetch=%0d data=%0d want %0d and %0d", iTotal, dTotal, wantI, wantD);
    end
    d_req = 0; if_req = 0; mem_ready = 0;
  endtask

  task automatic test_idle_ready();
    doReset();
    mem_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      vecs++;
      if (packObs() !== 134'd0) begin miss++; $display("FAIL idle_ready c%0d: dut=%h want=0", c, packObs()); end
    end
    mem_ready = 0;
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      vecs++;
      if (packObs() !== packExp()) begin miss++; $display("FAIL rand_model c%0d: dut=%h ref=%h", c, packObs(), packExp()); end
      vecs++;
      if (if_ack && d_ack) begin miss++; $display("FAIL rand_ack_excl c%0d: if_ack=%b d_ack=%b want not both", c, if_ack, d_ack); end
      reset = ($urandom_range(0, 249) == 0);
      if (!if_req || if_ack) begin if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom; end
      else if ($urandom_range(0, 7) == 0) if_addr = $urandom;
      if (!d_req || d_ack) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_wait_state();
    test_reset_mid_grant();
    test_fairness();
    test_idle_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
